// File: rtl/pdh_pkg.sv
// Shared types, constants and helpers for the PDH actuator output stage.
// Data paths are signed 16-bit; the DAC takes a 14-bit offset-binary word.
package pdh_pkg;

   localparam int DW    = 16;
   localparam int DAC_W = 14;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_LOCK  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_HOLD  = 2'd0;
   localparam logic [1:0] MODE_SWEEP = 2'd1;
   localparam logic [1:0] MODE_LOCK  = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

   function automatic logic signed [DW-1:0] sat16(input logic signed [DW+1:0] x);
      if (x > 18'sd32767) begin
         return 16'sh7FFF;
      end else if (x < -18'sd32768) begin
         return 16'sh8000;
      end else begin
         return x[DW-1:0];
      end
   endfunction

   // Upper bound applied first, so an inverted window resolves to lo.
   function automatic logic signed [DW-1:0] clamp_win(input logic signed [DW+1:0] x,
                                                      input logic signed [DW+1:0] lo,
                                                      input logic signed [DW+1:0] hi);
      logic signed [DW+1:0] y;
      y = x;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      return sat16(y);
   endfunction

   function automatic logic [DAC_W-1:0] to_offset_binary(input logic signed [DW-1:0] x);
      return {~x[DW-1], x[DW-2:2]};
   endfunction

endpackage

// File: rtl/pdh_actuator_out_slew_limiter.sv
// Combinational slew limiter: moves from cur_i toward tgt_i by at most slew_i.
// A slew of zero means the target is taken directly.
module slew_limiter
   import pdh_pkg::*;
(
   input  logic signed [DW-1:0] cur_i,
   input  logic signed [DW-1:0] tgt_i,
   input  logic        [DW-1:0] slew_i,
   output logic signed [DW-1:0] nxt_o,
   output logic                 limited_o
);

   logic signed [DW:0] delta;
   logic        [DW:0] mag;

   always_comb begin
      delta     = {tgt_i[DW-1], tgt_i} - {cur_i[DW-1], cur_i};
      mag       = delta[DW] ? (~delta + {{DW{1'b0}}, 1'b1}) : delta;
      limited_o = (slew_i != '0) && (mag > {1'b0, slew_i});
      nxt_o     = tgt_i;
      // The limited step always lands between cur and tgt, so 16 bits cannot wrap.
      if (limited_o) begin
         nxt_o = delta[DW] ? (cur_i - slew_i) : (cur_i + slew_i);
      end
   end

endmodule

// File: rtl/pdh_actuator_out.sv
// PDH actuator output: offset, window clamp and slew limit on the PID correction,
// plus a triangle acquisition sweep, driving an offset-binary DAC word.
module pdh_actuator_out
   import pdh_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic [1:0]           mode_i,
   input  logic signed [DW-1:0] pid_dat_i,
   input  logic                 pid_strobe_i,
   input  logic signed [DW-1:0] offset_i,
   input  logic signed [DW-1:0] lim_lo_i,
   input  logic signed [DW-1:0] lim_hi_i,
   input  logic [DW-1:0]        slew_i,
   input  logic [DW-1:0]        sweep_step_i,
   input  logic [DAC_W-1:0]     sweep_div_i,
   output logic [DAC_W-1:0]     dac_o,
   output logic                 dac_valid_o,
   output logic                 sat_o,
   output logic                 slew_o,
   output logic [1:0]           state_o
);

   state_t                state_q, state_d;
   logic signed [DW-1:0]  out_q, out_d;
   logic signed [DW-1:0]  target_q, target_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_sat_q, s1_sat_d;
   logic [DAC_W-1:0]      cnt_q, cnt_d;
   logic                  dir_dn_q, dir_dn_d;
   logic                  sat_q, sat_d;
   logic                  slew_q, slew_d;
   logic                  dac_valid_q, dac_valid_d;

   logic signed [DW+1:0]  lo_x, hi_x, lk_sum, sw_raw;
   logic signed [DW-1:0]  lk_tgt, sw_tgt, sl_tgt, sl_nxt;
   logic                  lk_sat, sw_turn_up, sw_turn_dn, sw_sat, sl_lim;

   always_comb begin
      lo_x       = {{2{lim_lo_i[DW-1]}}, lim_lo_i};
      hi_x       = {{2{lim_hi_i[DW-1]}}, lim_hi_i};
      lk_sum     = {{2{pid_dat_i[DW-1]}}, pid_dat_i} + {{2{offset_i[DW-1]}}, offset_i};
      lk_tgt     = clamp_win(lk_sum, lo_x, hi_x);
      lk_sat     = (lk_sum > hi_x) || (lk_sum < lo_x);
      sw_raw     = dir_dn_q ? ({{2{out_q[DW-1]}}, out_q} - {2'b00, sweep_step_i})
                            : ({{2{out_q[DW-1]}}, out_q} + {2'b00, sweep_step_i});
      sw_turn_up = !dir_dn_q && (sw_raw >= hi_x);
      sw_turn_dn = dir_dn_q && (sw_raw <= lo_x);
      sw_tgt     = clamp_win(sw_raw, lo_x, hi_x);
      sw_sat     = sw_turn_up || sw_turn_dn || (sw_raw > hi_x) || (sw_raw < lo_x);
      sl_tgt     = (state_q == ST_SWEEP) ? sw_tgt : target_q;
   end

   // Both paths slew from the live out_q, which is what makes handovers bumpless.
   slew_limiter u_slew (
      .cur_i     (out_q),
      .tgt_i     (sl_tgt),
      .slew_i    (slew_i),
      .nxt_o     (sl_nxt),
      .limited_o (sl_lim)
   );

   always_comb begin
      state_d = ST_IDLE;
      if (enable_i) begin
         case (mode_i)
            MODE_SWEEP: state_d = ST_SWEEP;
            MODE_LOCK:  state_d = ST_LOCK;
            default:    state_d = ST_HOLD;
         endcase
      end

      out_d       = out_q;
      target_d    = target_q;
      s1_valid_d  = 1'b0;
      s1_sat_d    = s1_sat_q;
      cnt_d       = '0;
      dir_dn_d    = dir_dn_q;
      sat_d       = sat_q;
      slew_d      = slew_q;
      dac_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            out_d    = '0;
            dir_dn_d = 1'b0;
            sat_d    = 1'b0;
            slew_d   = 1'b0;
         end
         ST_SWEEP: begin
            if (cnt_q >= sweep_div_i) begin
               out_d       = sl_nxt;
               sat_d       = sw_sat;
               slew_d      = sl_lim;
               dac_valid_d = 1'b1;
               if (sw_turn_up) begin
                  dir_dn_d = 1'b1;
               end else if (sw_turn_dn) begin
                  dir_dn_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + {{(DAC_W-1){1'b0}}, 1'b1};
            end
         end
         ST_LOCK: begin
            s1_valid_d = pid_strobe_i;
            if (pid_strobe_i) begin
               target_d = lk_tgt;
               s1_sat_d = lk_sat;
            end
            // Stage 2 only commits while still locked; otherwise the target is dropped.
            if (s1_valid_q) begin
               out_d       = sl_nxt;
               sat_d       = s1_sat_q;
               slew_d      = sl_lim;
               dac_valid_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         target_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_sat_q    <= 1'b0;
         cnt_q       <= '0;
         dir_dn_q    <= 1'b0;
         sat_q       <= 1'b0;
         slew_q      <= 1'b0;
         dac_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         target_q    <= target_d;
         s1_valid_q  <= s1_valid_d;
         s1_sat_q    <= s1_sat_d;
         cnt_q       <= cnt_d;
         dir_dn_q    <= dir_dn_d;
         sat_q       <= sat_d;
         slew_q      <= slew_d;
         dac_valid_q <= dac_valid_d;
      end
   end

   assign dac_o       = to_offset_binary(out_q);
   assign dac_valid_o = dac_valid_q;
   assign sat_o       = sat_q;
   assign slew_o      = slew_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pdh_actuator_out.sv
// Bench for pdh_actuator_out: directed scenarios plus randomized LOCK and SWEEP
// traffic compared against an arithmetic model of the output stage.
module tb_pdh_actuator_out;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               enable_i = 1'b0;
   logic [1:0]         mode_i = 2'd0;
   logic signed [15:0] pid_dat_i = '0;
   logic               pid_strobe_i = 1'b0;
   logic signed [15:0] offset_i = '0;
   logic signed [15:0] lim_lo_i = '0;
   logic signed [15:0] lim_hi_i = '0;
   logic [15:0]        slew_i = '0;
   logic [15:0]        sweep_step_i = '0;
   logic [13:0]        sweep_div_i = '0;
   logic [13:0]        dac_o;
   logic               dac_valid_o;
   logic               sat_o;
   logic               slew_o;
   logic [1:0]         state_o;

   int tests = 0;
   int fails = 0;

   // Reference model state: output value, sweep direction, last flags.
   int m_out = 0;
   bit m_up  = 1'b1;
   bit m_sat = 1'b0;
   bit m_slw = 1'b0;

   always #5 clk = ~clk;

   pdh_actuator_out dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .mode_i       (mode_i),
      .pid_dat_i    (pid_dat_i),
      .pid_strobe_i (pid_strobe_i),
      .offset_i     (offset_i),
      .lim_lo_i     (lim_lo_i),
      .lim_hi_i     (lim_hi_i),
      .slew_i       (slew_i),
      .sweep_step_i (sweep_step_i),
      .sweep_div_i  (sweep_div_i),
      .dac_o        (dac_o),
      .dac_valid_o  (dac_valid_o),
      .sat_o        (sat_o),
      .slew_o       (slew_o),
      .state_o      (state_o)
   );

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int ob(input int x);
      return ((x + 32768) >> 2) & 'h3FFF;
   endfunction

   function automatic int clampf(input int x);
      int y;
      y = (x > int'(lim_hi_i)) ? int'(lim_hi_i) : x;
      y = (y < int'(lim_lo_i)) ? int'(lim_lo_i) : y;
      return y;
   endfunction

   function automatic int slewf(input int cur, input int tgt, input int sl, output bit lim);
      int d;
      d   = tgt - cur;
      lim = (sl != 0) && ((d > sl) || (-d > sl));
      if (!lim) return tgt;
      return (d > 0) ? cur + sl : cur - sl;
   endfunction

   // n strobes on consecutive cycles; each result must appear two cycles later.
   task automatic lock_burst(input int n, input int pid_fixed, input bit rnd, input string tag);
      bit v1 = 0, v2 = 0, s1 = 0, s2 = 0;
      int t1 = 0, t2 = 0;
      for (int i = 0; i < n + 2; i++) begin
         if (v2) begin
            bit lim;
            int nx;
            nx = slewf(m_out, t2, int'(slew_i), lim);
            check_eq({tag, "_valid"}, dac_valid_o, 1);
            check_eq({tag, "_dac"}, dac_o, ob(nx));
            check_eq({tag, "_sat"}, sat_o, s2);
            check_eq({tag, "_slew"}, slew_o, lim);
            m_out = nx; m_sat = s2; m_slw = lim;
            $display("[TB] %s update out=%0d dac=0x%h sat=%0b slew=%0b", tag, nx, dac_o, sat_o, slew_o);
         end else begin
            check_eq({tag, "_novalid"}, dac_valid_o, 0);
         end
         v2 = v1; t2 = t1; s2 = s1;
         v1 = (i < n);
         if (v1) begin
            int p, sum;
            p = rnd ? (int'($urandom_range(0, 65535)) - 32768) : pid_fixed;
            sum = p + int'(offset_i);
            pid_dat_i = 16'(p);
            t1 = clampf(sum);
            s1 = (sum > int'(lim_hi_i)) || (sum < int'(lim_lo_i));
         end
         pid_strobe_i = v1;
         tick();
      end
   endtask

   // Enters SWEEP (counter restarts) and checks n_upd updates at period div+1.
   task automatic sweep_run(input int n_upd, input string tag);
      int period, k, seen;
      period = int'(sweep_div_i) + 1;
      k = 0; seen = 0;
      mode_i = 2'd1;
      while (seen < n_upd) begin
         bit exp_v;
         tick();
         k++;
         exp_v = (k >= 2) && (((k - 1) % period) == 0);
         check_eq({tag, "_valid"}, dac_valid_o, exp_v);
         if (exp_v) begin
            int raw, tgt, nx;
            bit turn, sat, lim;
            raw  = m_up ? m_out + int'(sweep_step_i) : m_out - int'(sweep_step_i);
            turn = m_up ? (raw >= int'(lim_hi_i)) : (raw <= int'(lim_lo_i));
            tgt  = clampf(raw);
            sat  = turn || (raw > int'(lim_hi_i)) || (raw < int'(lim_lo_i));
            nx   = slewf(m_out, tgt, int'(slew_i), lim);
            if (turn) m_up = !m_up;
            check_eq({tag, "_dac"}, dac_o, ob(nx));
            check_eq({tag, "_sat"}, sat_o, sat);
            check_eq({tag, "_slew"}, slew_o, lim);
            m_out = nx; m_sat = sat; m_slw = lim;
            seen++;
            $display("[TB] %s update out=%0d dac=0x%h sat=%0b slew=%0b", tag, nx, dac_o, sat_o, slew_o);
         end
      end
   endtask

   task automatic hold_run(input int n, input string tag);
      mode_i = 2'd0;
      tick();
      check_eq({tag, "_enter_novalid"}, dac_valid_o, 0);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq({tag, "_state"}, state_o, 3);
         check_eq({tag, "_novalid"}, dac_valid_o, 0);
         check_eq({tag, "_dac"}, dac_o, ob(m_out));
         check_eq({tag, "_sat"}, sat_o, m_sat);
         check_eq({tag, "_slew"}, slew_o, m_slw);
      end
      $display("[TB] %s held out=%0d for %0d cycles", tag, m_out, n);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      check_eq("rst_dac", dac_o, 'h2000);
      check_eq("rst_valid", dac_valid_o, 0);
      check_eq("rst_sat", sat_o, 0);
      check_eq("rst_slew", slew_o, 0);
      check_eq("rst_state", state_o, 0);

      rst = 1'b0;
      enable_i = 1'b1; mode_i = 2'd2;
      lim_lo_i = -16'sd32767; lim_hi_i = 16'sd32767;
      slew_i = '0; offset_i = '0;
      tick();
      check_eq("lock_state", state_o, 2);
      lock_burst(1, 1000, 0, "lock_basic");
      check_eq("lock_basic_word", dac_o, 'h20FA);

      lim_hi_i = 16'sd4000;
      lock_burst(1, 8192, 0, "lock_clamp_hi");
      check_eq("clamp_hi_word", dac_o, ob(4000));
      lim_lo_i = -16'sd4000;
      lock_burst(1, -8192, 0, "lock_clamp_lo");
      check_eq("clamp_lo_word", dac_o, ob(-4000));
      lock_burst(1, 0, 0, "lock_zero");

      slew_i = 16'd100;
      lock_burst(11, 1000, 0, "lock_slew");
      check_eq("slew_final_word", dac_o, ob(1000));

      hold_run(5, "hold");

      mode_i = 2'd2;
      tick();
      repeat (6) begin
         int lo_v, hi_v;
         lo_v = int'($urandom_range(0, 40000)) - 20000;
         hi_v = lo_v + int'($urandom_range(0, 30000)) - 2000;
         if (hi_v > 32767) hi_v = 32767;
         lim_lo_i = 16'(lo_v); lim_hi_i = 16'(hi_v);
         offset_i = 16'(int'($urandom_range(0, 20000)) - 10000);
         slew_i = $urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(1, 20000));
         lock_burst(8, 0, 1, "lock_rnd");
      end

      // Disable with a strobe in flight: the strobe must not produce an update.
      enable_i = 1'b0; pid_strobe_i = 1'b1; pid_dat_i = 16'sd3000;
      tick();
      pid_strobe_i = 1'b0;
      check_eq("dis_novalid1", dac_valid_o, 0);
      tick();
      check_eq("dis_novalid2", dac_valid_o, 0);
      check_eq("dis_state", state_o, 0);
      check_eq("dis_dac", dac_o, 'h2000);
      m_out = 0; m_up = 1'b1;

      enable_i = 1'b1; offset_i = '0; slew_i = '0;
      lim_lo_i = -16'sd1000; lim_hi_i = 16'sd1000;
      sweep_step_i = 16'd400; sweep_div_i = 14'd2;
      sweep_run(4, "sweep");
      check_eq("sweep_at_600", dac_o, ob(600));

      slew_i = 16'd50;
      mode_i = 2'd2;
      tick();
      check_eq("handover_novalid", dac_valid_o, 0);
      check_eq("handover_state", state_o, 2);
      lock_burst(1, 0, 0, "bumpless");
      check_eq("bumpless_word", dac_o, ob(550));

      slew_i = '0;
      sweep_run(4, "sweep2");
      check_eq("sweep2_turn_sat", sat_o, 1);

      #2 rst = 1'b1;
      #1;
      check_eq("arst_dac", dac_o, 'h2000);
      check_eq("arst_valid", dac_valid_o, 0);
      check_eq("arst_sat", sat_o, 0);
      check_eq("arst_slew", slew_o, 0);
      check_eq("arst_state", state_o, 0);
      tick();
      rst = 1'b0;
      m_out = 0; m_up = 1'b1; m_sat = 1'b0; m_slw = 1'b0;

      repeat (3) begin
         lim_lo_i = 16'(-int'($urandom_range(500, 20000)));
         lim_hi_i = 16'($urandom_range(500, 20000));
         sweep_step_i = 16'($urandom_range(1, 6000));
         sweep_div_i = 14'($urandom_range(1, 4));
         slew_i = $urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(1, 3000));
         sweep_run(12, "sweep_rnd");
         hold_run(2, "hold_rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
